// File: rtl/pcie_tx_arb.sv
// rtl/pcie_tx_arb.sv - packet-granular round-robin merge of AXI-S PCIe TX sources.
// Optional macro PCIE_TX_ARB_PRIO0_EN: source 0 wins every IDLE arbitration.
module pcie_tx_arb #(
  parameter int NUM_SRC = 4,
  parameter int TDATA_W = 512,
  parameter int TUSER_W = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SRC-1:0]           src_tvalid,
  output logic [NUM_SRC-1:0]           src_tready,
  input  logic [NUM_SRC-1:0]           src_tlast,
  input  logic [NUM_SRC*TDATA_W-1:0]   src_tdata,
  input  logic [NUM_SRC*TUSER_W-1:0]   src_tuser,
  output logic                         out_tvalid,
  input  logic                         out_tready,
  output logic                         out_tlast,
  output logic [TDATA_W-1:0]           out_tdata,
  output logic [TUSER_W-1:0]           out_tuser,
  output logic [$clog2(NUM_SRC)-1:0]   out_src_id
);
  localparam int IDW = $clog2(NUM_SRC);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDW-1:0]     r_rr_ptr, w_rr_nxt;
  logic [IDW-1:0]     r_owner, w_owner_nxt;
  logic [1:0]         r_cnt;
  logic               r_wr, r_rd;
  logic [TDATA_W-1:0] r_data [2];
  logic [TUSER_W-1:0] r_user [2];
  logic               r_last [2];
  logic [IDW-1:0]     r_id   [2];

  logic               w_space, w_found, w_push, w_pop, w_sel_last, w_rr_hold;
  logic [IDW-1:0]     w_winner, w_sel, w_sel_inc;
  logic [NUM_SRC-1:0] w_grant;

  assign w_space = (r_cnt != 2'd2);

  // Rotating scan starting at r_rr_ptr; first valid source wins.
  always_comb begin
    int v_idx;
    v_idx    = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= NUM_SRC) v_idx = v_idx - NUM_SRC;
      if (!w_found && src_tvalid[v_idx]) begin
        w_found  = 1'b1;
        w_winner = IDW'(v_idx);
      end
    end
`ifdef PCIE_TX_ARB_PRIO0_EN
    if (src_tvalid[0]) begin
      w_found  = 1'b1;
      w_winner = '0;
    end
`endif
  end

`ifdef PCIE_TX_ARB_PRIO0_EN
  // Every grant to source 0 is a priority win, so it never moves the pointer.
  assign w_rr_hold = (w_sel == '0);
`else
  assign w_rr_hold = 1'b0;
`endif

  assign w_sel     = (r_state == ST_LOCKED) ? r_owner : w_winner;
  assign w_sel_inc = (w_sel == IDW'(NUM_SRC - 1)) ? '0 : w_sel + 1'b1;

  always_comb begin
    w_grant = '0;
    if (r_state == ST_LOCKED)
      w_grant[r_owner] = 1'b1;
    else if (w_found)
      w_grant[w_winner] = 1'b1;
  end

  assign src_tready = (rst_n && w_space) ? w_grant : '0;
  assign w_push     = |(src_tvalid & src_tready);
  assign w_sel_last = src_tlast[w_sel];
  assign w_pop      = (r_cnt != 2'd0) && out_tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_owner  <= w_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_owner_nxt = r_owner;
    if (w_push) begin
      if (w_sel_last) begin
        w_state_nxt = ST_IDLE;
        if (!w_rr_hold) w_rr_nxt = w_sel_inc;
      end else begin
        w_state_nxt = ST_LOCKED;
        w_owner_nxt = w_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      for (int e = 0; e < 2; e++) begin
        r_data[e] <= '0;
        r_user[e] <= '0;
        r_last[e] <= 1'b0;
        r_id[e]   <= '0;
      end
    end else begin
      if (w_push) begin
        r_data[r_wr] <= src_tdata[int'(w_sel)*TDATA_W +: TDATA_W];
        r_user[r_wr] <= src_tuser[int'(w_sel)*TUSER_W +: TUSER_W];
        r_last[r_wr] <= w_sel_last;
        r_id[r_wr]   <= w_sel;
        r_wr         <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign out_tvalid = (r_cnt != 2'd0);
  assign out_tdata  = r_data[r_rd];
  assign out_tuser  = r_user[r_rd];
  assign out_tlast  = r_last[r_rd];
  assign out_src_id = r_id[r_rd];

endmodule

// File: tb/tb_pcie_tx_arb.sv
// tb/tb_pcie_tx_arb.sv - scoreboard bench for pcie_tx_arb with random sources.
module tb_pcie_tx_arb;
  localparam int N  = 4;
  localparam int DW = 512;
  localparam int UW = 10;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    src_tvalid, src_tready, src_tlast;
  logic [N*DW-1:0] src_tdata;
  logic [N*UW-1:0] src_tuser;
  logic            out_tvalid, out_tready, out_tlast;
  logic [DW-1:0]   out_tdata;
  logic [UW-1:0]   out_tuser;
  logic [IW-1:0]   out_src_id;

  pcie_tx_arb #(.NUM_SRC(N), .TDATA_W(DW), .TUSER_W(UW)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_tvalid(src_tvalid), .src_tready(src_tready), .src_tlast(src_tlast),
    .src_tdata(src_tdata), .src_tuser(src_tuser),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .out_tdata(out_tdata), .out_tuser(out_tuser), .out_src_id(out_src_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic          l;
    int            id;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Source generators: each holds its current beat until accepted.
  logic [DW-1:0] s_data [N];
  logic [UW-1:0] s_user [N];
  logic          s_last [N];
  logic          s_vld  [N];
  int            s_rem  [N];

  // Reference model: owner (-1 = none), round-robin pointer, buffer occupancy.
  int m_owner, m_rr, m_cnt;
  int p_valid, p_ready, maxlen, bp_mode, cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic chk_data(input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL out_tdata: got %h expected %h", act, req);
  endtask

  task automatic gen_beat(input int i, input int ml);
    logic [DW-1:0] d;
    if (s_rem[i] == 0) s_rem[i] = int'($urandom_range(ml, 1));
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    s_data[i] = d;
    s_user[i] = UW'($urandom);
    s_last[i] = (s_rem[i] == 1);
    s_vld[i]  = 1'b1;
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      src_tvalid[i]           = s_vld[i];
      src_tlast[i]            = s_last[i];
      src_tdata[i*DW +: DW]   = s_data[i];
      src_tuser[i*UW +: UW]   = s_user[i];
    end
  endtask

  function automatic int model_grant();
    int g;
    g = -1;
    if (m_owner >= 0) return m_owner;
`ifdef PCIE_TX_ARB_PRIO0_EN
    if (s_vld[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (g < 0 && s_vld[(m_rr + k) % N]) g = (m_rr + k) % N;
    end
    return g;
  endfunction

  task automatic cycle();
    int g;
    logic [N-1:0] exp_rdy;
    bit acc, pop;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++)
      if (!s_vld[i] && int'($urandom_range(99)) < p_valid) gen_beat(i, maxlen);
    drive_src();
    if (bp_mode != 0) out_tready = ((cyc % 10) >= 5);
    else              out_tready = (int'($urandom_range(99)) < p_ready);
    cyc++;
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0 && m_cnt < 2) exp_rdy[g] = 1'b1;
    chk("src_tready", 64'(src_tready), 64'(exp_rdy));
    chk("out_tvalid", 64'(out_tvalid), 64'(m_cnt != 0));
    @(posedge clk);
    acc = (g >= 0) && s_vld[g] && (m_cnt < 2);
    pop = (m_cnt > 0) && out_tready;
    if (acc) begin
      exp_q.push_back('{d: s_data[g], u: s_user[g], l: s_last[g], id: g});
      s_vld[g] = 1'b0;
      s_rem[g] = s_rem[g] - 1;
      if (s_last[g]) begin
        m_owner = -1;
`ifdef PCIE_TX_ARB_PRIO0_EN
        if (g != 0) m_rr = (g + 1) % N;
`else
        m_rr = (g + 1) % N;
`endif
      end else begin
        m_owner = g;
      end
    end
    m_cnt = m_cnt + int'(acc) - int'(pop);
  endtask

  task automatic do_reset(input int ncyc);
    for (int i = 0; i < N; i++) begin
      s_rem[i] = 0;
      gen_beat(i, maxlen);
    end
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      rst_n      = 1'b0;
      out_tready = 1'b0;
      drive_src();
      #1;
      chk("reset_src_tready", 64'(src_tready), 64'd0);
      if (k > 0) chk("reset_out_tvalid", 64'(out_tvalid), 64'd0);
      @(posedge clk);
    end
    m_owner = -1;
    m_rr    = 0;
    m_cnt   = 0;
    exp_q.delete();
  endtask

  task automatic run_phase(input int pv, input int pr, input int ml, input int bp, input int ncyc);
    p_valid = pv;
    p_ready = pr;
    maxlen  = ml;
    bp_mode = bp;
    for (int c = 0; c < ncyc; c++) cycle();
  endtask

  // Monitor: head of the scoreboard must be presented whenever out_tvalid is high.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && out_tvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", 64'(out_src_id), 64'hFFFF);
        end else begin
          e = exp_q[0];
          chk_data(out_tdata, e.d);
          chk("out_tuser", 64'(out_tuser), 64'(e.u));
          chk("out_tlast", 64'(out_tlast), 64'(e.l));
          chk("out_src_id", 64'(out_src_id), 64'(e.id));
          if (out_tready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    out_tready = 1'b0;
    src_tvalid = '0;
    src_tlast  = '0;
    src_tdata  = '0;
    src_tuser  = '0;
    cyc        = 0;
    maxlen     = 1;
    for (int i = 0; i < N; i++) begin
      s_vld[i] = 1'b0; s_rem[i] = 0; s_last[i] = 1'b0;
      s_data[i] = '0;  s_user[i] = '0;
    end
    do_reset(3);
    run_phase(100, 100, 1, 0, 200);
    run_phase(100, 100, 4, 0, 300);
    run_phase(100, 100, 4, 1, 300);
    run_phase(50, 60, 4, 0, 2000);
    do_reset(2);
    run_phase(70, 80, 3, 0, 1000);
    run_phase(30, 50, 5, 1, 500);
    run_phase(0, 100, 1, 0, 40);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_out_tvalid", 64'(out_tvalid), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pcie_tx_arb.md
# pcie_tx_arb

Packet-granular round-robin arbiter that merges several AXI-S PCIe TX sources (FIM-internal requesters such as MMIO completion, DMA/host-channel and management paths) into the single TX stream that feeds the channel-0 realignment stage ahead of the PCIe SS. A source, once granted, owns the output until its tlast beat is accepted, so TLPs are never interleaved. Output is fully registered through a 2-entry buffer, giving 1-cycle latency at full throughput.

## Interface
- NUM_SRC, 4: number of requesters, 2..8.
- TDATA_W, 512: beat data width (both TLP channels, header+payload, incl. per-channel valid/sop/eop).
- TUSER_W, 10: beat sideband width.
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- src_tvalid  in  NUM_SRC  per-source beat valid.
- src_tready  out  NUM_SRC  per-source beat accept.
- src_tlast  in  NUM_SRC  per-source last beat of packet.
- src_tdata  in  NUM_SRC*TDATA_W  source i at bits [i*TDATA_W +: TDATA_W].
- src_tuser  in  NUM_SRC*TUSER_W  source i at bits [i*TUSER_W +: TUSER_W].
- out_tvalid  out  1  merged beat valid.
- out_tready  in  1  downstream accept.
- out_tlast  out  1  merged last beat.
- out_tdata  out  TDATA_W  merged data.
- out_tuser  out  TUSER_W  merged sideband.
- out_src_id  out  $clog2(NUM_SRC)  source index of the current out beat.

## Operation
- States: IDLE (no owner), LOCKED (owner register valid).
- Beat accept from source i: src_tvalid[i] && src_tready[i]. src_tready[i] = buf_space && grant[i]; buf_space = (buf_cnt != 2), registered-derived, no combinational path from out_tready.
- IDLE grant: first i with src_tvalid[i], scanning rr_ptr, rr_ptr+1, … mod NUM_SRC. Grant is combinational in IDLE (no bubble cycle).
  - Accepted beat with tlast: stay IDLE; rr_ptr <= winner+1 mod NUM_SRC.
  - Accepted beat without tlast: go LOCKED, owner <= winner.
  - No accept (buffer full): no state change, grant re-evaluated next cycle.
- LOCKED: grant only to owner; other sources' src_tready = 0 regardless of their tvalid. On owner tlast accept: go IDLE, rr_ptr <= owner+1 mod NUM_SRC.
- Buffer: 2-entry FIFO of {tdata, tuser, tlast, src_id}; head drives out_*. Push on source accept, pop on out_tvalid && out_tready, simultaneous push/pop keeps buf_cnt. out_tvalid = (buf_cnt != 0).
- Beats are passed unmodified; no TLP parsing. Ordering within a source preserved; packet order across sources follows grant order.
- Reset (rst_n=0 at posedge): state IDLE, rr_ptr 0, owner 0, buf_cnt 0. Outputs: out_tvalid 0, out_tlast 0, out_tdata 0, out_tuser 0, out_src_id 0, src_tready all 0 during the reset cycle. Reset mid-packet discards buffered beats and ownership; sources must also be reset.

## Timing
- Latency: beat accepted at cycle N appears on out_* at N+1 (buffer empty case).
- Throughput: 1 beat/cycle sustained while out_tready = 1, including back-to-back packets from different sources (IDLE arbitration costs zero cycles).
- Backpressure: out_tready low 2 cycles fills buffer; src_tready drops the cycle after buf_cnt reaches 2; resumes the cycle after the first pop.
- out_* stable while out_tvalid && !out_tready (AXI-S rule).
- Source violating AXI-S (dropping tvalid mid-packet) simply stalls LOCKED; no timeout.

## Configuration
- PCIE_TX_ARB_PRIO0_EN defined: in IDLE, source 0 wins whenever src_tvalid[0], ignoring rr_ptr; rr_ptr is not updated by a source-0 priority win. Packet locking still applies (source 0 cannot preempt a LOCKED owner).
- Undefined: pure round-robin for all sources, source 0 has no precedence.

## Test plan
- Reset: hold rst_n=0 with all src_tvalid=1 -> out_tvalid=0, src_tready=0; first grant after release to source 0, out beat at +1 cycle.
- RR fairness: 4 sources each sending continuous 1-beat packets, out_tready=1 -> out_src_id sequence 0,1,2,3,0,… one beat per cycle.
- Locking: source 1 sends 4-beat packet while source 2 valid -> 4 consecutive beats out_src_id=1, src_tready[2]=0 throughout, then source 2 granted with no gap.
- Backpressure: out_tready=0 for 5 cycles mid-packet -> exactly 2 beats buffered, no beat lost/duplicated, data order matches input after release.
- Wrap: rr_ptr=3, sources 0 and 2 valid -> source 0 granted, then source 2.
- PRIO0 (macro defined): source 0 and 3 continuously valid with 1-beat packets, rr_ptr=3 -> source 0 wins every IDLE arbitration; undefined -> alternates 3,0,3,0.
